// File: rtl/aes_enc_iter_if.sv
// aes_enc_iter_if: request/result bundle between the block controller (master) and the AES core (slave).
interface aes_enc_iter_if #(
    parameter int KEY_BITS = 128
);
    logic                start;
    logic [127:0]        data_in;
    logic [KEY_BITS-1:0] key_in;
    logic [127:0]        data_out;
    logic                done;
    logic                busy;
    modport master (output start, data_in, key_in, input data_out, done, busy);
    modport slave (input start, data_in, key_in, output data_out, done, busy);
endinterface

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128/256 encryptor, one round per clock, key schedule expanded on the fly.
// Optional debug taps trace_round/trace_rkey exist only when AES_ROUND_TRACE_EN is defined.
module aes_enc_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic          clk,
    input  logic          reset,
    aes_enc_iter_if.slave bus
`ifdef AES_ROUND_TRACE_EN
    ,
    output logic [3:0]    trace_round,
    output logic [127:0]  trace_rkey
`endif
);
    localparam int NK = KEY_BITS / 32;
    localparam logic [3:0] NR = 4'(NK + 6);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_enc_iter: KEY_BITS must be 128 or 256");
    end
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [31:0] mix_col(input logic [0:3][7:0] a);
        return {xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3],
                a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3],
                a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3],
                xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3])};
    endfunction
    typedef enum logic {IDLE, ROUND} state_t;
    state_t              st, st_n;
    logic [3:0]          round, round_n;
    logic [127:0]        blk, blk_n, dout_n, rk, new4, rnd_out;
    logic [KEY_BITS-1:0] win, win_n, win_upd;
    logic [7:0]          rcon, rcon_n;
    logic                done_n, busy_n, step_a, last;
    logic [31:0]         ksub, kt;
    logic [0:3][31:0]    nw;
    logic [0:15][7:0]    s_in, s_sb, s_sr, s_mc;
    // Key path: SubWord(RotWord(x)) == RotWord(SubWord(x)), so one set of four S-boxes serves both steps.
    always_comb begin
        ksub = {sbox(win[31:24]), sbox(win[23:16]), sbox(win[15:8]), sbox(win[7:0])};
        step_a = (NK == 4) || round[0];
        kt = step_a ? {ksub[23:0], ksub[31:24]} ^ {rcon, 24'h0} : ksub;
        nw[0] = win[KEY_BITS-1 -: 32] ^ kt;
        nw[1] = win[KEY_BITS-33 -: 32] ^ nw[0];
        nw[2] = win[KEY_BITS-65 -: 32] ^ nw[1];
        nw[3] = win[KEY_BITS-97 -: 32] ^ nw[2];
    end
    assign new4 = nw;
    if (NK == 4) begin : g_k128
        assign rk      = new4;
        assign win_upd = new4;
    end else begin : g_k256
        assign rk      = win[127:0];
        assign win_upd = {win[127:0], new4};
    end
    always_comb begin
        s_in = blk;
        for (int i = 0; i < 16; i++) s_sb[i] = sbox(s_in[i]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s_sr[4*c+r] = s_sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) s_mc[4*c +: 4] = mix_col(s_sr[4*c +: 4]);
        last = round == NR;
        rnd_out = (last ? s_sr : s_mc) ^ rk;
    end
    always_comb begin
        st_n    = st;
        round_n = round;
        blk_n   = blk;
        win_n   = win;
        rcon_n  = rcon;
        dout_n  = bus.data_out;
        done_n  = 1'b0;
        busy_n  = bus.busy;
        if (st == IDLE) begin
            if (bus.start) begin
                st_n    = ROUND;
                round_n = 4'd1;
                blk_n   = bus.data_in ^ bus.key_in[KEY_BITS-1 -: 128];
                win_n   = bus.key_in;
                rcon_n  = 8'h01;
                busy_n  = 1'b1;
            end
        end else if (last) begin
            st_n    = IDLE;
            round_n = 4'd0;
            dout_n  = rnd_out;
            done_n  = 1'b1;
            busy_n  = 1'b0;
        end else begin
            round_n = round + 4'd1;
            blk_n   = rnd_out;
            win_n   = win_upd;
            rcon_n  = step_a ? xt(rcon) : rcon;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= IDLE;
            round        <= '0;
            blk          <= '0;
            win          <= '0;
            rcon         <= '0;
            bus.data_out <= '0;
            bus.done     <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            st           <= st_n;
            round        <= round_n;
            blk          <= blk_n;
            win          <= win_n;
            rcon         <= rcon_n;
            bus.data_out <= dout_n;
            bus.done     <= done_n;
            bus.busy     <= busy_n;
        end
    end
`ifdef AES_ROUND_TRACE_EN
    assign trace_round = round;
    assign trace_rkey  = bus.busy ? rk : '0;
`endif
endmodule
